telemetry_counter_gen: RTL and testbench

TELEMETRY_COUNTER_GEN -- requirements
Module: telemetry_counter_gen

---
 rtl/telemetry_counter_gen.sv | 150 +++++++++++++++
 tb/tb_telemetry_counter_gen.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/telemetry_counter_gen.sv
// Telemetry packet generator: emits one fixed-format packet per slot period,
// carrying a 10-bit sequence number, with drop/corrupt fault injection and
// counters for accepted packets and slots lost while a packet was pending.
`timescale 1ns/1ps

module telemetry_counter_gen #(
    parameter logic [15:0] G_PERIOD    = 16'd410,
    parameter logic [3:0]  G_STREAM_ID = 4'hD
) (
    input  logic        clk_256M,
    input  logic        reset,
    input  logic        enable,
    input  logic        packet_ready,
    input  logic        inject_drop,
    input  logic        inject_corrupt,
    output logic [87:0] packet_data,
    output logic        packet_valid,
    output logic [31:0] sent_packets,
    output logic [31:0] overrun_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        SEND = 2'd2
    } state_t;

    state_t      state;
    state_t      next_state;
    logic [15:0] slot_timer;
    logic        tick;
    logic [9:0]  seq;
    logic [9:0]  payload;
    logic        drop_flag;
    logic        corrupt_flag;
    logic        drop_consume;
    logic        send_start;
    logic        accept;
    logic        overrun_tick;

    // Slot tick fires on the last count of the period, only while enabled
    always_comb begin
        tick = enable && (slot_timer == (G_PERIOD - 16'd1));
    end

    // Slot timer: free-running while enabled, parked at zero otherwise
    always_ff @(posedge clk_256M or posedge reset) begin
        if (reset) begin
            slot_timer <= 16'd0;
        end else if (!enable || tick) begin
            slot_timer <= 16'd0;
        end else begin
            slot_timer <= slot_timer + 16'd1;
        end
    end

    // Decode the per-cycle events that drive both the FSM and the datapath
    always_comb begin
        drop_consume = (state == WAIT) && tick && drop_flag;
        send_start   = (state == WAIT) && tick && !drop_flag;
        accept       = (state == SEND) && packet_ready;
        overrun_tick = (state == SEND) && tick;
        payload      = corrupt_flag ? (seq ^ 10'h001) : seq;
    end

    // FSM state register
    always_ff @(posedge clk_256M or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // FSM next-state logic; a packet in SEND always finishes its handshake
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (enable) begin
                    next_state = WAIT;
                end
            end
            WAIT: begin
                if (send_start) begin
                    next_state = SEND;
                end else if (!enable) begin
                    next_state = IDLE;
                end
            end
            SEND: begin
                if (accept) begin
                    next_state = enable ? WAIT : IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // FSM outputs: valid is high exactly while a packet is pending
    always_comb begin
        packet_valid = (state == SEND);
    end

    // Fault flags are sticky until consumed; a request that coincides with
    // consumption stays pending for the following slot
    always_ff @(posedge clk_256M or posedge reset) begin
        if (reset) begin
            drop_flag    <= 1'b0;
            corrupt_flag <= 1'b0;
        end else begin
            drop_flag    <= (drop_flag && !drop_consume) || inject_drop;
            corrupt_flag <= (corrupt_flag && !send_start) || inject_corrupt;
        end
    end

    // Packet register is loaded on entry to SEND and held until accepted
    always_ff @(posedge clk_256M or posedge reset) begin
        if (reset) begin
            packet_data <= 88'd0;
        end else if (send_start) begin
            packet_data <= {4'h0, G_STREAM_ID, 70'd0, payload};
        end
    end

    // Sequence advances on every accepted packet and every dropped slot
    always_ff @(posedge clk_256M or posedge reset) begin
        if (reset) begin
            seq <= 10'd0;
        end else if (accept || drop_consume) begin
            seq <= seq + 10'd1;
        end
    end

    // Statistics counters, both wrapping naturally at 2^32
    always_ff @(posedge clk_256M or posedge reset) begin
        if (reset) begin
            sent_packets  <= 32'd0;
            overrun_count <= 32'd0;
        end else begin
            if (accept) begin
                sent_packets <= sent_packets + 32'd1;
            end
            if (overrun_tick) begin
                overrun_count <= overrun_count + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_telemetry_counter_gen.sv
// Directed bench for telemetry_counter_gen with a payload scoreboard: each
// step pushes the payloads it should produce, a negedge monitor pops and
// compares them at every handshake and checks held data while stalled.
`timescale 1ns/1ps

module tb_telemetry_counter_gen;

    localparam logic [3:0] STREAM = 4'hD;

    logic        clk_256M = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic        packet_ready = 1'b1;
    logic        inject_drop = 1'b0;
    logic        inject_corrupt = 1'b0;
    logic [87:0] packet_data;
    logic        packet_valid;
    logic [31:0] sent_packets;
    logic [31:0] overrun_count;

    int          checks = 0;
    int          errors = 0;
    int          exp_sent = 0;
    logic [9:0]  exp_q[$];

    always #5 clk_256M = ~clk_256M;

    telemetry_counter_gen #(
        .G_PERIOD(16'd4),
        .G_STREAM_ID(STREAM)
    ) dut (
        .clk_256M(clk_256M),
        .reset(reset),
        .enable(enable),
        .packet_ready(packet_ready),
        .inject_drop(inject_drop),
        .inject_corrupt(inject_corrupt),
        .packet_data(packet_data),
        .packet_valid(packet_valid),
        .sent_packets(sent_packets),
        .overrun_count(overrun_count)
    );

    function automatic logic [87:0] make_packet(input logic [9:0] p);
        return {4'h0, STREAM, 70'd0, p};
    endfunction

    // One comparison: count it, and on mismatch count and report the failure
    task automatic checkOutput(input string tag, input logic [87:0] observed,
                               input logic [87:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Drive all control inputs at once
    task automatic applyStimulus(input logic en, input logic rdy,
                                 input logic drop, input logic corrupt);
        enable         = en;
        packet_ready   = rdy;
        inject_drop    = drop;
        inject_corrupt = corrupt;
    endtask

    // Advance one clock and settle just after the active edge
    task automatic step();
        @(posedge clk_256M);
        #1;
    endtask

    // Wait until every expected payload has been seen, bounded by a budget
    task automatic drain(input string tag, input int budget);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (exp_q.size() != 0 && n < budget);
        checkOutput(tag, 88'(exp_q.size()), 88'd0);
    endtask

    // Scoreboard monitor: sampled on the falling edge, away from the active edge
    always @(negedge clk_256M) begin
        if (!reset && packet_valid) begin
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_packet", 88'(exp_q.size()), 88'd1);
            end else if (packet_ready) begin
                checkOutput("payload", packet_data, make_packet(exp_q.pop_front()));
            end else begin
                checkOutput("held_payload", packet_data, make_packet(exp_q[0]));
            end
        end
    end

    initial begin
        $display("[TB] start");
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        reset = 1'b1;
        repeat (3) step();
        checkOutput("reset_valid", 88'(packet_valid), 88'd0);
        checkOutput("reset_data", packet_data, 88'd0);
        checkOutput("reset_sent", 88'(sent_packets), 88'd0);
        checkOutput("reset_overrun", 88'(overrun_count), 88'd0);
        reset = 1'b0;

        // Disabled: no packets may appear
        for (int i = 0; i < 6; i++) begin
            step();
            checkOutput("disabled_valid", 88'(packet_valid), 88'd0);
        end

        // Basic stream 0..5, first packet exactly four edges after enable
        for (int i = 0; i < 6; i++) exp_q.push_back(10'(i));
        exp_sent += 6;
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            checkOutput("startup_valid_low", 88'(packet_valid), 88'd0);
        end
        step();
        checkOutput("first_valid_high", 88'(packet_valid), 88'd1);
        checkOutput("first_payload", packet_data, make_packet(10'h000));
        drain("drain_basic", 40);
        checkOutput("sent_basic", 88'(sent_packets), 88'(exp_sent));
        checkOutput("overrun_basic", 88'(overrun_count), 88'd0);

        // Drop after payload 5: one empty slot, then 7, 8
        exp_q.push_back(10'd7);
        exp_q.push_back(10'd8);
        exp_sent += 2;
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
        step();
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            checkOutput("dropped_slot_valid", 88'(packet_valid), 88'd0);
            step();
        end
        drain("drain_drop", 40);
        checkOutput("sent_drop", 88'(sent_packets), 88'(exp_sent));

        // Corrupt before payload 9: 9^1 = 8, then 10
        exp_q.push_back(10'd8);
        exp_q.push_back(10'd10);
        exp_sent += 2;
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
        step();
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        drain("drain_corrupt", 40);
        checkOutput("sent_corrupt", 88'(sent_packets), 88'(exp_sent));

        // Drop and corrupt together: slot 11 skipped, 12^1 = 13, then 13, 14
        exp_q.push_back(10'd13);
        exp_q.push_back(10'd13);
        exp_q.push_back(10'd14);
        exp_sent += 3;
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
        step();
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        drain("drain_drop_corrupt", 60);
        checkOutput("sent_drop_corrupt", 88'(sent_packets), 88'(exp_sent));

        // Sink stalls for 10 cycles: packet 15 held, two ticks lost
        exp_q.push_back(10'd15);
        exp_sent += 1;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (10) step();
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        drain("drain_stall", 20);
        checkOutput("overrun_stall", 88'(overrun_count), 88'd2);
        checkOutput("sent_stall", 88'(sent_packets), 88'(exp_sent));

        // Reset while a packet is pending
        exp_q.push_back(10'd16);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            step();
            if (packet_valid) break;
        end
        checkOutput("valid_before_reset", 88'(packet_valid), 88'd1);
        reset = 1'b1;
        #1;
        checkOutput("mid_send_reset_valid", 88'(packet_valid), 88'd0);
        checkOutput("mid_send_reset_data", packet_data, 88'd0);
        checkOutput("mid_send_reset_sent", 88'(sent_packets), 88'd0);
        checkOutput("mid_send_reset_overrun", 88'(overrun_count), 88'd0);
        exp_q.delete();

        // Long run from reset: 1030 packets crossing 3FF -> 000
        for (int i = 0; i < 1030; i++) exp_q.push_back(10'(i));
        exp_sent = 1030;
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        repeat (3) step();
        reset = 1'b0;
        drain("drain_wrap", 4400);
        checkOutput("sent_wrap", 88'(sent_packets), 88'(exp_sent));
        checkOutput("overrun_wrap", 88'(overrun_count), 88'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
